// File: rtl/cdb_pkg.sv
// Shared constants and types for the common-data-bus arbiter.
// Holds default widths, the tag type and the two-state bus encoding.
package cdb_pkg;

    localparam int CDB_N_REQ  = 4;
    localparam int CDB_DATA_W = 16;
    localparam int CDB_TAG_W  = 3;

    typedef logic [CDB_TAG_W-1:0] cdb_tag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        BCAST = 1'b1
    } cdb_state_e;

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// Round-robin winner search starting at ptr_i and wrapping modulo N_REQ.
// Purely combinational: one-hot winner, its index and an any-request flag.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IW-1:0]    ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [IW-1:0]    idx_o,
    output logic             any_o
);

    int          j;
    logic [IW-1:0] jj;

    // Walk from the farthest slot back to ptr so the nearest requester wins last
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(ptr_i) + k;
            if (j >= N_REQ) j = j - N_REQ;
            jj = IW'(j);
            if (req_i[jj]) begin
                gnt_o     = '0;
                gnt_o[jj] = 1'b1;
                idx_o     = jj;
                any_o     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter driving a registered common data bus broadcast.
// Optional macro CDB_ARB_STATS_EN adds a saturating Bcast_Count output.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int N_REQ  = CDB_N_REQ,
    parameter int DATA_W = CDB_DATA_W,
    parameter int TAG_W  = CDB_TAG_W
) (
    input  logic                    Clock,
    input  logic                    Resetn,
    input  logic [N_REQ-1:0]        Req,
    input  logic [N_REQ*DATA_W-1:0] Data_in,
    input  logic [N_REQ*TAG_W-1:0]  Tag_in,
    input  logic                    Stall,
    output logic [N_REQ-1:0]        Grant,
    output logic                    CDB_Valid,
    output logic [DATA_W-1:0]       CDB_Data,
    output logic [TAG_W-1:0]        CDB_Tag
`ifdef CDB_ARB_STATS_EN
    ,
    output logic [15:0]             Bcast_Count
`endif
);

    localparam int IW = $clog2(N_REQ);

    cdb_state_e        state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [TAG_W-1:0]  tag_q, tag_d;

    logic [N_REQ-1:0]  pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;
    logic              grant_en;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req_i (Req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    assign grant_en = Resetn & ~Stall & pick_any;
    assign Grant    = grant_en ? pick_gnt : '0;

    // State, pointer and bus payload registers with synchronous reset
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            data_q  <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
        end
    end

    // Next state: a grant latches the winner's payload and advances the pointer
    always_comb begin
        state_d = grant_en ? BCAST : IDLE;
        ptr_d   = ptr_q;
        data_d  = data_q;
        tag_d   = tag_q;
        if (grant_en) begin
            ptr_d  = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + IW'(1);
            data_d = Data_in[int'(pick_idx)*DATA_W +: DATA_W];
            tag_d  = Tag_in[int'(pick_idx)*TAG_W +: TAG_W];
        end
    end

    // Outputs: bus is valid exactly in the cycle after a grant
    always_comb begin
        CDB_Valid = (state_q == BCAST);
        CDB_Data  = data_q;
        CDB_Tag   = tag_q;
    end

`ifdef CDB_ARB_STATS_EN
    logic [15:0] cnt_q;

    // Saturating count of granted edges
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            cnt_q <= '0;
        end else if (grant_en && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign Bcast_Count = cnt_q;
`endif

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of functional units sharing the CDB (2..8).
REQ-002 Parameter DATA_W, default 16, SHALL set the result width.
REQ-003 Parameter TAG_W, default 3, SHALL set the reservation-station tag width.
REQ-004 Port Clock, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port Resetn, input, 1, SHALL be the synchronous, active-low reset.
REQ-006 Port Req, input, N_REQ, SHALL carry per-unit broadcast requests (the unit's Write_Enable_CDB).
REQ-007 Port Data_in, input, N_REQ*DATA_W, SHALL carry per-unit results; slice i belongs to unit i.
REQ-008 Port Tag_in, input, N_REQ*TAG_W, SHALL carry per-unit producer tags; slice i belongs to unit i.
REQ-009 Port Stall, input, 1, SHALL inhibit all grants while high.
REQ-010 Port Grant, output, N_REQ, SHALL be a one-hot-or-zero per-unit acceptance.
REQ-011 Ports CDB_Valid (1), CDB_Data (DATA_W) and CDB_Tag (TAG_W), outputs, SHALL carry the registered bus broadcast.

Function
REQ-012 Grant SHALL be combinational from Req, Stall, Resetn and the pointer Ptr, with at most one bit high.
REQ-013 The winner SHALL be the first i with Req[i]=1 when searching Ptr, Ptr+1, ... and wrapping modulo N_REQ.
REQ-014 On an edge where Grant[w]=1, CDB_Valid SHALL become 1, CDB_Data SHALL become Data_in[w] and CDB_Tag SHALL become Tag_in[w], giving a one-cycle latency.
REQ-015 On an edge with no grant, CDB_Valid SHALL become 0 and CDB_Data/CDB_Tag SHALL hold their values.
REQ-016 On a granted edge, Ptr SHALL become (w+1) mod N_REQ, wrapping from N_REQ-1 to 0; otherwise Ptr SHALL hold.
REQ-017 A requester SHALL hold Req, Data_in and Tag_in stable until it samples Grant high, and the arbiter SHALL never drop or duplicate a held request.
REQ-018 A requester that keeps Req high in the cycle after its grant SHALL be treated as presenting a new result.
REQ-019 Stall=1 SHALL force Grant=0 and hold Ptr; CDB_Valid SHALL be 0 on the following cycle.
REQ-020 With all N_REQ requests held continuously, each unit SHALL be granted exactly once per N_REQ consecutive unstalled cycles.
REQ-021 The arbiter SHALL have two states: IDLE (previous cycle had no grant) and BCAST (previous cycle granted). Any grant SHALL move it to BCAST; no grant SHALL move it to IDLE. CDB_Valid SHALL equal (state==BCAST).

Reset
REQ-022 On a rising edge with Resetn=0, the block SHALL set state=IDLE, CDB_Valid=0, CDB_Data=0, CDB_Tag=0 and Ptr=0.
REQ-023 Grant SHALL be all-zero while Resetn=0, including a reset asserted mid-stream; a pending request SHALL be re-arbitrated after reset.

Configuration
REQ-024 With macro CDB_ARB_STATS_EN defined, the block SHALL add output Bcast_Count (16 bits), a saturating count of granted edges that is cleared by reset and holds at 16'hFFFF.
REQ-025 Without CDB_ARB_STATS_EN, the Bcast_Count port and its counter SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Shared package cdb_pkg SHALL hold the default DATA_W, TAG_W and N_REQ constants, the cdb_tag_t typedef and the IDLE/BCAST state encoding.
REQ-027 The round-robin search SHALL live in a combinational sub-module rr_pick (inputs Req and Ptr; output a one-hot winner and its index).

Verification
REQ-028 Reset, then Req=0001, Data0=16'h0005, Tag0=3'd2 -> Grant=0001 in that cycle; next cycle CDB_Valid=1, CDB_Data=0005, CDB_Tag=2 and Ptr=1.
REQ-029 Req=1111 held for 8 cycles starting from Ptr=0 -> grant order 0,1,2,3,0,1,2,3 with CDB_Valid=1 on every cycle.
REQ-030 Ptr=3 with Req=1001 -> Grant=1000, then Ptr wraps to 0 and the next grant is 0001.
REQ-031 Req=0110 with Stall=1 for 3 cycles -> Grant=0, CDB_Valid=0 and Ptr unchanged; on Stall release, unit 1 is granted first.
REQ-032 Resetn=0 asserted in the cycle after a grant -> next cycle CDB_Valid=0, CDB_Data=0 and Ptr=0; the held Req=0100 is re-granted after release.
REQ-033 With CDB_ARB_STATS_EN defined, 5 grants -> Bcast_Count=5; with the counter preloaded near saturation, it stays at 16'hFFFF.
